div_arbiter: RTL

//  Shares one unsigned 32/32 iterative divider core between two issue pipes.

---
 rtl/div_arbiter.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/div_arbiter.sv
// -----------------------------------------------------------------------------
// div_arbiter
//   Shares one unsigned iterative divider core between two issue pipes.
//   A request is arbitrated round-robin. Signed (DIV) operands are converted to
//   magnitudes before the core is launched. The core result is then sign-fixed
//   using the MIPS rules: the quotient is negative when the operand signs
//   differ, and the remainder takes the sign of the dividend. The quotient (LO)
//   and remainder (HI) are returned to the pipe that owns the operation.
//   A division by zero bypasses the core. It returns LO = all ones and
//   HI = dividend.
//
// Parameters
//   NREQ   number of requesters (the arbiter is written for exactly 2)
//   DW     operand width
//
// Ports
//   clk, reset             clock, synchronous active-high reset
//   req_valid/req_ready    per-pipe request handshake
//   req_signed             per-pipe 1 = DIV, 0 = DIVU
//   req_a/req_b            packed operands, pipe i in bits [i*DW +: DW]
//   flush                  kills any accepted, unreturned operation
//   resp_valid             one-cycle result pulse to the owning pipe
//   resp_lo/resp_hi        quotient/remainder, held until the next response
//   busy                   high whenever the FSM is not idle
//   core_valid             one-cycle launch pulse to the divider core
//   core_a/core_b          operand magnitudes for the core
//   core_done              core finishing (ignored in the launch cycle)
//   core_res               {remainder, quotient}, valid one cycle after core_done
// -----------------------------------------------------------------------------
module div_arbiter #(
    parameter int NREQ = 2,
    parameter int DW   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_signed,
    input  logic [NREQ*DW-1:0]   req_a,
    input  logic [NREQ*DW-1:0]   req_b,
    input  logic                 flush,
    output logic [NREQ-1:0]      resp_valid,
    output logic [DW-1:0]        resp_lo,
    output logic [DW-1:0]        resp_hi,
    output logic                 busy,
    output logic                 core_valid,
    output logic [DW-1:0]        core_a,
    output logic [DW-1:0]        core_b,
    input  logic                 core_done,
    input  logic [2*DW-1:0]      core_res
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_FIX    = 3'd3,
        S_RESP   = 3'd4,
        S_DRAIN  = 3'd5
    } state_t;

    // Magnitude of a possibly signed operand. The most negative value maps to itself.
    function automatic logic [DW-1:0] abs_val(input logic [DW-1:0] x, input logic is_signed);
        return (is_signed && x[DW-1]) ? -x : x;
    endfunction

    // Conditional two's-complement negation used by the sign fix-up.
    function automatic logic [DW-1:0] cond_neg(input logic [DW-1:0] x, input logic neg);
        return neg ? -x : x;
    endfunction

    state_t             state_q, state_d;
    logic               rr_q, rr_d;
    logic               owner_q, owner_d;
    logic               sa_q, sa_d;
    logic               sb_q, sb_d;
    logic [DW-1:0]      core_a_q, core_a_d;
    logic [DW-1:0]      core_b_q, core_b_d;
    logic [DW-1:0]      resp_lo_q, resp_lo_d;
    logic [DW-1:0]      resp_hi_q, resp_hi_d;
    logic               core_valid_q, core_valid_d;
    logic               busy_q, busy_d;
    logic [NREQ-1:0]    resp_pend_q, resp_pend_d;

    logic [NREQ-1:0]    grant_s;
    logic               accept_s;
    logic               sel_s;
    logic [DW-1:0]      sel_a_s;
    logic [DW-1:0]      sel_b_s;
    logic               sel_signed_s;
    logic [DW-1:0]      uq_s;
    logic [DW-1:0]      ur_s;

    // Round-robin grant: on contention the pipe that did not win last time wins.
    always_comb begin
        grant_s = 2'b00;
        if (req_valid == 2'b11) begin
            grant_s = rr_q ? 2'b01 : 2'b10;
        end else begin
            grant_s = req_valid;
        end
    end

    // Handshake: only an idle, unflushed, out-of-reset arbiter accepts.
    always_comb begin
        req_ready = 2'b00;
        if ((state_q == S_IDLE) && !flush && !reset) begin
            req_ready = grant_s;
        end else begin
            req_ready = 2'b00;
        end
    end

    // Operand select for the winning pipe.
    always_comb begin
        accept_s     = |req_ready;
        sel_s        = grant_s[1];
        sel_a_s      = sel_s ? req_a[2*DW-1:DW] : req_a[DW-1:0];
        sel_b_s      = sel_s ? req_b[2*DW-1:DW] : req_b[DW-1:0];
        sel_signed_s = sel_s ? req_signed[1] : req_signed[0];
        uq_s         = core_res[DW-1:0];
        ur_s         = core_res[2*DW-1:DW];
    end

    // Next-state and next-register computation for the whole controller.
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        owner_d   = owner_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        core_a_d  = core_a_q;
        core_b_d  = core_b_q;
        resp_lo_d = resp_lo_q;
        resp_hi_d = resp_hi_q;

        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    rr_d     = sel_s;
                    owner_d  = sel_s;
                    sa_d     = sel_signed_s & sel_a_s[DW-1];
                    sb_d     = sel_signed_s & sel_b_s[DW-1];
                    core_a_d = abs_val(sel_a_s, sel_signed_s);
                    core_b_d = abs_val(sel_b_s, sel_signed_s);
                    if (sel_b_s == '0) begin
                        // Divide by zero never reaches the core.
                        resp_lo_d = '1;
                        resp_hi_d = sel_a_s;
                        state_d   = S_RESP;
                    end else begin
                        state_d   = S_LAUNCH;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LAUNCH: begin
                // The launch pulse goes out regardless. A flush here must still drain.
                state_d = flush ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                if (flush) begin
                    // If the core finishes in the flush cycle, nothing is left to drain.
                    state_d = core_done ? S_IDLE : S_DRAIN;
                end else if (core_done) begin
                    state_d = S_FIX;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_FIX: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    resp_lo_d = cond_neg(uq_s, sa_q ^ sb_q);
                    resp_hi_d = cond_neg(ur_s, sa_q);
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            S_DRAIN: begin
                state_d = core_done ? S_IDLE : S_DRAIN;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the state being entered.
        core_valid_d = (state_d == S_LAUNCH);
        busy_d       = (state_d != S_IDLE);
        if (state_d == S_RESP) begin
            resp_pend_d = owner_d ? 2'b10 : 2'b01;
        end else begin
            resp_pend_d = 2'b00;
        end
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rr_q         <= 1'b0;
            owner_q      <= 1'b0;
            sa_q         <= 1'b0;
            sb_q         <= 1'b0;
            core_a_q     <= '0;
            core_b_q     <= '0;
            resp_lo_q    <= '0;
            resp_hi_q    <= '0;
            core_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            resp_pend_q  <= 2'b00;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            owner_q      <= owner_d;
            sa_q         <= sa_d;
            sb_q         <= sb_d;
            core_a_q     <= core_a_d;
            core_b_q     <= core_b_d;
            resp_lo_q    <= resp_lo_d;
            resp_hi_q    <= resp_hi_d;
            core_valid_q <= core_valid_d;
            busy_q       <= busy_d;
            resp_pend_q  <= resp_pend_d;
        end
    end

    // A flush arriving during the response cycle suppresses the pulse.
    always_comb begin
        if (flush) begin
            resp_valid = 2'b00;
        end else begin
            resp_valid = resp_pend_q;
        end
    end

    assign resp_lo    = resp_lo_q;
    assign resp_hi    = resp_hi_q;
    assign busy       = busy_q;
    assign core_valid = core_valid_q;
    assign core_a     = core_a_q;
    assign core_b     = core_b_q;

endmodule
